// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: T1..T6 ring counter with run/step control, sticky HALT
// and a combinational control word. Define SEQ_EARLY_END_EN to end LDA/OUT/NOP early.
module sap1_controller_sequencer #(
  parameter bit HALT_ON_UNDEF = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       lda,
  input  logic       add,
  input  logic       sub,
  input  logic       out,
  input  logic       low_halt,
  input  logic       run,
  input  logic       step,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_ld,
  output logic       ram_en,
  output logic       ir_ld,
  output logic       ir_en,
  output logic       a_ld,
  output logic       a_en,
  output logic       alu_sub,
  output logic       alu_en,
  output logic       b_ld,
  output logic       out_ld,
  output logic [5:0] t_state,
  output logic       instr_done,
  output logic       halted
);

`ifdef SEQ_EARLY_END_EN
  localparam bit EARLY_END = 1'b1;
`else
  localparam bit EARLY_END = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   step_q, step_d;

  logic adv;
  logic is_hlt, is_lda, is_add, is_sub, is_out, is_nop;
  logic halt_req, short_t4, short_t5;

  // HLT outranks every other decoder output; the rest resolve lda > add > sub > out.
  always_comb begin
    is_hlt   = ~low_halt;
    is_lda   = low_halt & lda;
    is_add   = low_halt & ~lda & add;
    is_sub   = low_halt & ~lda & ~add & sub;
    is_out   = low_halt & ~lda & ~add & ~sub & out;
    is_nop   = low_halt & ~(lda | add | sub | out);
    halt_req = is_hlt | (HALT_ON_UNDEF & is_nop);
    short_t4 = EARLY_END & (is_out | is_nop);
    short_t5 = EARLY_END & is_lda;
    adv      = run | (step & ~step_q);
  end

  always_comb begin
    state_d = state_q;
    step_d  = step;
    if (adv) begin
      unique case (state_q)
        S_T1:    state_d = S_T2;
        S_T2:    state_d = S_T3;
        S_T3:    state_d = S_T4;
        S_T4:    state_d = halt_req ? S_HALT : (short_t4 ? S_T1 : S_T5);
        S_T5:    state_d = short_t5 ? S_T1 : S_T6;
        S_T6:    state_d = S_T1;
        default: state_d = S_HALT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_T1;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    pc_inc     = 1'b0;
    pc_en      = 1'b0;
    mar_ld     = 1'b0;
    ram_en     = 1'b0;
    ir_ld      = 1'b0;
    ir_en      = 1'b0;
    a_ld       = 1'b0;
    a_en       = 1'b0;
    alu_sub    = 1'b0;
    alu_en     = 1'b0;
    b_ld       = 1'b0;
    out_ld     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    t_state    = 6'b000001;
    if (!clr) begin
      unique case (state_q)
        S_T1: begin
          t_state = 6'b000001;
          pc_en   = 1'b1;
          mar_ld  = 1'b1;
        end
        S_T2: begin
          t_state = 6'b000010;
          pc_inc  = 1'b1;
        end
        S_T3: begin
          t_state = 6'b000100;
          ram_en  = 1'b1;
          ir_ld   = 1'b1;
        end
        S_T4: begin
          t_state    = 6'b001000;
          instr_done = halt_req | short_t4;
          if (!halt_req) begin
            ir_en  = is_lda | is_add | is_sub;
            mar_ld = is_lda | is_add | is_sub;
            a_en   = is_out;
            out_ld = is_out;
          end
        end
        S_T5: begin
          t_state    = 6'b010000;
          instr_done = short_t5;
          ram_en     = is_lda | is_add | is_sub;
          a_ld       = is_lda;
          b_ld       = is_add | is_sub;
        end
        S_T6: begin
          t_state    = 6'b100000;
          instr_done = 1'b1;
          alu_en     = is_add | is_sub;
          a_ld       = is_add | is_sub;
          alu_sub    = is_sub;
        end
        default: begin
          t_state = 6'b000000;
          halted  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for sap1_controller_sequencer; expectations follow SEQ_EARLY_END_EN.
module tb_sap1_controller_sequencer;

  logic clk, clr, lda, add, sub, out, low_halt, run, step;
  logic pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en, a_ld, a_en;
  logic alu_sub, alu_en, b_ld, out_ld, instr_done, halted;
  logic [5:0] t_state;
  logic [11:0] cw;

  int checks = 0;
  int failures = 0;

`ifdef SEQ_EARLY_END_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif

  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;
  localparam logic [5:0] TH = 6'b000000;

  localparam logic [11:0] PC_INC = 12'h800, PC_EN = 12'h400, MAR_LD = 12'h200;
  localparam logic [11:0] RAM_EN = 12'h100, IR_LD = 12'h080, IR_EN = 12'h040;
  localparam logic [11:0] A_LD = 12'h020, A_EN = 12'h010, ALU_SUB = 12'h008;
  localparam logic [11:0] ALU_EN = 12'h004, B_LD = 12'h002, OUT_LD = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  sap1_controller_sequencer dut (
    .clk(clk), .clr(clr), .lda(lda), .add(add), .sub(sub), .out(out),
    .low_halt(low_halt), .run(run), .step(step),
    .pc_inc(pc_inc), .pc_en(pc_en), .mar_ld(mar_ld), .ram_en(ram_en),
    .ir_ld(ir_ld), .ir_en(ir_en), .a_ld(a_ld), .a_en(a_en),
    .alu_sub(alu_sub), .alu_en(alu_en), .b_ld(b_ld), .out_ld(out_ld),
    .t_state(t_state), .instr_done(instr_done), .halted(halted)
  );

  assign cw = {pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en,
               a_ld, a_en, alu_sub, alu_en, b_ld, out_ld};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected are packed as {t_state, control word, instr_done, halted}.
  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got t=%06b cw=%03h done=%b halt=%b, expected t=%06b cw=%03h done=%b halt=%b",
               tag, got[19:14], got[13:2], got[1], got[0],
               exp[19:14], exp[13:2], exp[1], exp[0]);
    end
  endtask

  task automatic cmp(input string tag, input logic [5:0] t, input logic [11:0] c,
                     input logic d, input logic h);
    check(tag, {t_state, cw, instr_done, halted}, {t, c, d, h});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sc(input string tag, input logic [5:0] t, input logic [11:0] c,
                    input logic d, input logic h);
    cmp(tag, t, c, d, h);
    tick();
  endtask

  task automatic set_op(input logic l, input logic a, input logic s, input logic o,
                        input logic lh);
    lda = l; add = a; sub = s; out = o; low_halt = lh;
  endtask

  task automatic fetch(input string tag);
    sc({tag, "_t1"}, T1, PC_EN | MAR_LD, 1'b0, 1'b0);
    sc({tag, "_t2"}, T2, PC_INC, 1'b0, 1'b0);
    sc({tag, "_t3"}, T3, RAM_EN | IR_LD, 1'b0, 1'b0);
  endtask

  task automatic lda_instr(input string tag);
    fetch(tag);
    sc({tag, "_t4"}, T4, IR_EN | MAR_LD, 1'b0, 1'b0);
`ifdef SEQ_EARLY_END_EN
    sc({tag, "_t5"}, T5, RAM_EN | A_LD, 1'b1, 1'b0);
`else
    sc({tag, "_t5"}, T5, RAM_EN | A_LD, 1'b0, 1'b0);
    sc({tag, "_t6"}, T6, NONE, 1'b1, 1'b0);
`endif
  endtask

  task automatic out_instr(input string tag);
    fetch(tag);
`ifdef SEQ_EARLY_END_EN
    sc({tag, "_t4"}, T4, A_EN | OUT_LD, 1'b1, 1'b0);
`else
    sc({tag, "_t4"}, T4, A_EN | OUT_LD, 1'b0, 1'b0);
    sc({tag, "_t5"}, T5, NONE, 1'b0, 1'b0);
    sc({tag, "_t6"}, T6, NONE, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; step = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    cmp("reset", T1, NONE, 1'b0, 1'b0);
    clr = 1'b0;
    #1;
    cmp("reset_rel", T1, PC_EN | MAR_LD, 1'b0, 1'b0);
    tick();
    cmp("idle_hold", T1, PC_EN | MAR_LD, 1'b0, 1'b0);

    // Free-run ADD then SUB.
    run = 1'b1;
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    fetch("add");
    sc("add_t4", T4, IR_EN | MAR_LD, 1'b0, 1'b0);
    sc("add_t5", T5, RAM_EN | B_LD, 1'b0, 1'b0);
    sc("add_t6", T6, ALU_EN | A_LD, 1'b1, 1'b0);
    set_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    fetch("sub");
    sc("sub_t4", T4, IR_EN | MAR_LD, 1'b0, 1'b0);
    sc("sub_t5", T5, RAM_EN | B_LD, 1'b0, 1'b0);
    sc("sub_t6", T6, ALU_EN | A_LD | ALU_SUB, 1'b1, 1'b0);

    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    lda_instr("lda");
    // lda wins over add and sub when several are asserted.
    set_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    lda_instr("prio");

    // Undefined opcode executes as NOP with the default HALT_ON_UNDEF.
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch("nop");
`ifdef SEQ_EARLY_END_EN
    sc("nop_t4", T4, NONE, 1'b1, 1'b0);
`else
    sc("nop_t4", T4, NONE, 1'b0, 1'b0);
    sc("nop_t5", T5, NONE, 1'b0, 1'b0);
    sc("nop_t6", T6, NONE, 1'b1, 1'b0);
`endif

    // OUT then HLT; out stays asserted during HLT to exercise halt priority.
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    out_instr("out");
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    fetch("hlt");
    sc("hlt_t4", T4, NONE, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) sc("halt_hold", TH, NONE, 1'b0, 1'b1);

    // clr leaves HALT immediately.
    run = 1'b0;
    #2 clr = 1'b1;
    #1 cmp("clr_halt", T1, NONE, 1'b0, 1'b0);
    #2 clr = 1'b0;
    tick();
    cmp("clr_halt_rel", T1, PC_EN | MAR_LD, 1'b0, 1'b0);

    // clr pulse in LDA T5 while free-running.
    run = 1'b1;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fetch("ldac");
    sc("ldac_t4", T4, IR_EN | MAR_LD, 1'b0, 1'b0);
    cmp("ldac_t5", T5, RAM_EN | A_LD, EE, 1'b0);
    #2 clr = 1'b1;
    #1 cmp("clr_mid", T1, NONE, 1'b0, 1'b0);
    tick();
    cmp("clr_edge", T1, NONE, 1'b0, 1'b0);
    #2 clr = 1'b0;
    #1 cmp("clr_mid_rel", T1, PC_EN | MAR_LD, 1'b0, 1'b0);
    tick();
    cmp("clr_next", T2, PC_INC, 1'b0, 1'b0);

    // Step mode: a held step advances once, separate pulses advance once each.
    run = 1'b0;
    #2 clr = 1'b1;
    #2 clr = 1'b0;
    tick();
    cmp("step_idle", T1, PC_EN | MAR_LD, 1'b0, 1'b0);
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp("step_held", T2, PC_INC, 1'b0, 1'b0);
    end
    step = 1'b0;
    tick();
    cmp("step_low", T2, PC_INC, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0; tick();
    cmp("step_p1", T3, RAM_EN | IR_LD, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0; tick();
    cmp("step_p2", T4, IR_EN | MAR_LD, 1'b0, 1'b0);
    step = 1'b1; tick(); step = 1'b0; tick();
    cmp("step_p3", T5, RAM_EN | A_LD, EE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap1_controller_sequencer.md
# sap1_controller_sequencer

Controller-sequencer for the SAP-1 datapath. Consumes the one-hot instruction-decoder outputs (`lda`, `add`, `sub`, `out`, `low_halt`) and runs a 6-state ring counter (T1–T6). From that state it drives the active-high control word for the PC, MAR, RAM, IR, accumulator, B register, ALU and output register. Also provides run/single-step control and a sticky halt. It sits between the instruction decoder and every datapath load/enable.

## Interface
- `HALT_ON_UNDEF`, default 0: when 1, an opcode with no decoder output asserted and `low_halt`=1 halts the machine; when 0 it executes as NOP.
- `clk` input 1: single clock; all state updates on the rising edge.
- `clr` input 1: reset, asynchronous and active-high.
- `lda`, `add`, `sub`, `out` input 1 each: decoder outputs, valid from T4 onward (IR is loaded at the end of T3).
- `low_halt` input 1: 0 means the current opcode is HLT.
- `run` input 1: 1 means free-run; 0 means single-step mode.
- `step` input 1: in step mode, each 0→1 transition advances exactly one T-state; level input, edge-detected internally.
- `pc_inc`, `pc_en`, `mar_ld`, `ram_en`, `ir_ld`, `ir_en`, `a_ld`, `a_en`, `alu_sub`, `alu_en`, `b_ld`, `out_ld` output 1 each: active-high control word.
- `t_state` output 6: one-hot ring state; bit0 = T1 … bit5 = T6; all zeros when halted.
- `instr_done` output 1: high during the last T-state of each instruction.
- `halted` output 1: high in the HALT state.

## Operation
- **State register:** T1..T6 plus HALT.
- **Advance enable:** `adv` = `run` | (`step` & ~`step_q`).
  - `step_q` is registered every clock, including in HALT.
  - With `adv`=0 the state holds, and the outputs hold their combinational values.
- **Control word:** combinational from the state and decoder inputs. Unlisted signals are 0.
  - T1: `pc_en`, `mar_ld`.
  - T2: `pc_inc`.
  - T3: `ram_en`, `ir_ld`.
  - LDA: T4 `ir_en`, `mar_ld`; T5 `ram_en`, `a_ld`; T6 none.
  - ADD: T4 `ir_en`, `mar_ld`; T5 `ram_en`, `b_ld`; T6 `alu_en`, `a_ld`.
  - SUB: as ADD, plus `alu_sub` in T6.
  - OUT: T4 `a_en`, `out_ld`; T5 and T6 none.
  - NOP/undefined: T4–T6 none.
- **Transitions:**
  - Tn→Tn+1 on `adv`; T6→T1.
  - In T4 with `low_halt`=0 (or undefined opcode and `HALT_ON_UNDEF`=1), the control word is all zero and `adv` moves to HALT instead of T5.
- **HALT:** sticky. All controls 0, `t_state`=0, `halted`=1. Only `clr` exits.
- **Input priority:** `low_halt`=0 has priority over any other decoder output.
  - If more than one of `lda`/`add`/`sub`/`out` is asserted, the decode priority is lda > add > sub > out.
- **`instr_done`:**
  - High in T6, or in the early-end state (see Configuration).
  - Also high in T4 of HLT.
  - Independent of `adv`.
- **Reset** (`clr`=1, immediate, at any state including mid-instruction and HALT):
  - State → T1, `step_q` → 0.
  - All control outputs, `instr_done` and `halted` are forced to 0 while `clr` is high.
  - `t_state`=000001 while `clr` is high.
  - The first advance after `clr` falls is from T1.

## Timing
- Every control signal is valid for the whole state. The datapath captures on the rising edge that leaves the state.
- **Free-run:** one T-state per clock; a full instruction takes 6 clocks (fewer with early end).
- **Step mode:** a `step` 0→1 seen on edge k advances at edge k. A held-high `step` gives exactly one advance.
- **`run` changes:** take effect on the next edge; no partial states.
- **HLT:** HALT is entered at the first `adv` edge after T4. `halted` rises in the same cycle that HALT is entered.

## Configuration
- **`SEQ_EARLY_END_EN` defined:** variable machine cycle.
  - LDA returns T5→T1; OUT and NOP return T4→T1.
  - `instr_done` is high in those final states.
  - ADD and SUB still use T1–T6.
- **Not defined:** every non-halting instruction takes exactly T1–T6.

## Test plan
- `clr` pulse in LDA T5 with `run`=1 → `t_state`=000001 immediately, all controls 0 during `clr`; next edge gives T2 with `pc_inc`=1.
- Free-run ADD (`add`=1 from T4) → per clock: {pc_en,mar_ld}, {pc_inc}, {ram_en,ir_ld}, {ir_en,mar_ld}, {ram_en,b_ld}, {alu_en,a_ld}; `instr_done`=1 only in T6; then T1.
- SUB → identical to ADD, plus `alu_sub`=1 only in T6.
- OUT followed by HLT (`low_halt`=0 at second T4) → `a_en`,`out_ld` in the first T4; then `halted`=1, `t_state`=0; state held for 20 clocks with `run`=1.
- Step mode, `run`=0: `step` held high for 5 clocks → exactly one advance (T1→T2); three separate pulses → T5.
- `SEQ_EARLY_END_EN` on: LDA completes in 5 clocks and OUT in 4, with `instr_done` in T5/T4 respectively. Macro off: both take 6 clocks.
